// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the fft_32 family: transform size, bin index width
// and the power-accumulator frame-tracking states.
package dsp_pkg;
   localparam int FFT_32_LENGTH      = 32;
   localparam int FFT_32_INDEX_WIDTH = 5;

   typedef enum logic {
      S_ACCUM  = 1'b0,
      S_RESYNC = 1'b1
   } fft_32_power_state_t;
endpackage

// File: rtl/fft_32_power_accum_ram.sv
// 32-entry simple dual-port accumulator store with a registered read port.
// A write and a read to the same address in one cycle return the new data.
module fft_32_power_accum_ram
   import dsp_pkg::*;
#(
   parameter int ACCUM_WIDTH = 48
) (
   input  logic                          clk,
   input  logic                          wr_en,
   input  logic [FFT_32_INDEX_WIDTH-1:0] wr_addr,
   input  logic [ACCUM_WIDTH-1:0]        wr_data,
   input  logic [FFT_32_INDEX_WIDTH-1:0] rd_addr,
   output logic [ACCUM_WIDTH-1:0]        rd_data
);
   logic [ACCUM_WIDTH-1:0] mem [FFT_32_LENGTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
   end
endmodule

// File: rtl/fft_32_power_accum.sv
// Per-bin |X|^2 integration over Num_frames fft_32 frames, with frame-sequence checking.
// Optional peak-bin tracker enabled by defining FFT_32_POWER_ACCUM_PEAK_EN.
module fft_32_power_accum
   import dsp_pkg::*;
#(
   parameter int INPUT_DATA_WIDTH = 21,
   parameter int ACCUM_WIDTH      = 48,
   parameter int NUM_FRAMES_WIDTH = 8
) (
   input  logic                               Clk,
   input  logic                               Rst_n,
   input  logic [NUM_FRAMES_WIDTH-1:0]        Num_frames,
   input  logic                               Input_valid,
   input  logic signed [INPUT_DATA_WIDTH-1:0] Input_i,
   input  logic signed [INPUT_DATA_WIDTH-1:0] Input_q,
   input  logic [FFT_32_INDEX_WIDTH-1:0]      Input_index,
   input  logic                               Input_last,
   output logic                               Output_valid,
   output logic [ACCUM_WIDTH-1:0]             Output_power,
   output logic [FFT_32_INDEX_WIDTH-1:0]      Output_index,
   output logic                               Output_last,
   output logic                               Peak_valid,
   output logic [FFT_32_INDEX_WIDTH-1:0]      Peak_index,
   output logic [ACCUM_WIDTH-1:0]             Peak_power,
   output logic                               Error_overflow,
   output logic                               Error_frame
);
   localparam int PW = 2 * INPUT_DATA_WIDTH;
   localparam int IW = FFT_32_INDEX_WIDTH;
   localparam int AW = ACCUM_WIDTH;
   localparam int NW = NUM_FRAMES_WIDTH;

   // Returns {carry, result}; result clamps to all-ones when the add wraps.
   function automatic logic [AW:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
      logic [AW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[AW]) s = {1'b1, {AW{1'b1}}};
      return s;
   endfunction

   fft_32_power_state_t state;
   logic [IW-1:0] expected;
   logic [NW-1:0] frame_count, n_lat, n_in, n_eff;
   logic          idx_ok, accept, is_final, err_frame;

   always_comb begin
      n_in     = (Num_frames == '0) ? NW'(1) : Num_frames;
      n_eff    = ((frame_count == '0) && (Input_index == '0)) ? n_in : n_lat;
      is_final = (frame_count == (n_eff - NW'(1)));
      idx_ok   = (Input_index == expected) &&
                 (Input_last == (Input_index == IW'(FFT_32_LENGTH - 1)));
      accept   = (state == S_ACCUM) && Input_valid && idx_ok;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state       <= S_ACCUM;
         expected    <= '0;
         frame_count <= '0;
         n_lat       <= NW'(1);
         err_frame   <= 1'b0;
      end else begin
         err_frame <= 1'b0;
         case (state)
            S_ACCUM: if (Input_valid) begin
               if (idx_ok) begin
                  expected <= expected + IW'(1);
                  if ((frame_count == '0) && (Input_index == '0)) n_lat <= n_in;
                  if (Input_last) frame_count <= is_final ? '0 : frame_count + NW'(1);
               end else begin
                  err_frame   <= 1'b1;
                  frame_count <= '0;
                  state       <= S_RESYNC;
               end
            end
            S_RESYNC: if (Input_valid && Input_last) begin
               expected <= '0;
               state    <= S_ACCUM;
            end
            default: state <= S_ACCUM;
         endcase
      end
   end

   logic                 vld_p1, vld_p2, vld_p3, ovf_p3;
   logic signed [PW-1:0] ii_p1, qq_p1;
   logic [PW-1:0]        pwr_p2;
   logic [IW-1:0]        idx_p1, idx_p2, idx_p3;
   logic                 last_p1, last_p2, last_p3;
   logic                 first_p1, first_p2, final_p1, final_p2, final_p3;
   logic [AW-1:0]        acc_p3, rd_data, rd_fwd, pwr_ext;
   logic [AW:0]          sum_sat;

   // Back-to-back hits on one bin only happen around a resync; forward the P3 result.
   always_comb begin
      pwr_ext = AW'(pwr_p2);
      rd_fwd  = (vld_p3 && (idx_p3 == idx_p2)) ? acc_p3 : rd_data;
      sum_sat = sat_add(rd_fwd, pwr_ext);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
         ovf_p3 <= 1'b0;
      end else begin
         vld_p1 <= accept;
         vld_p2 <= vld_p1;
         vld_p3 <= vld_p2;
         ovf_p3 <= vld_p2 && !first_p2 && sum_sat[AW];
      end
   end

   always_ff @(posedge Clk) begin
      // P1: squares
      ii_p1    <= PW'(Input_i) * PW'(Input_i);
      qq_p1    <= PW'(Input_q) * PW'(Input_q);
      idx_p1   <= Input_index;
      last_p1  <= Input_last;
      first_p1 <= (frame_count == '0);
      final_p1 <= is_final;
      // P2: power sum, RAM read data arrives
      pwr_p2   <= $unsigned(ii_p1) + $unsigned(qq_p1);
      idx_p2   <= idx_p1;
      last_p2  <= last_p1;
      first_p2 <= first_p1;
      final_p2 <= final_p1;
      // P3: accumulate / overwrite
      acc_p3   <= first_p2 ? pwr_ext : sum_sat[AW-1:0];
      idx_p3   <= idx_p2;
      last_p3  <= last_p2;
      final_p3 <= final_p2;
   end

   fft_32_power_accum_ram #(.ACCUM_WIDTH(AW)) u_ram (
      .clk     (Clk),
      .wr_en   (vld_p3 && !final_p3),
      .wr_addr (idx_p3),
      .wr_data (acc_p3),
      .rd_addr (idx_p1),
      .rd_data (rd_data)
   );

   assign Output_valid   = vld_p3 & final_p3;
   assign Output_power   = Output_valid ? acc_p3 : '0;
   assign Output_index   = Output_valid ? idx_p3 : '0;
   assign Output_last    = Output_valid & last_p3;
   assign Error_overflow = ovf_p3;
   assign Error_frame    = err_frame;

`ifdef FFT_32_POWER_ACCUM_PEAK_EN
   logic [AW-1:0] run_pow, cand_pow;
   logic [IW-1:0] run_idx, cand_idx;

   // Strict greater-than keeps the lowest index on ties; bin 0 restarts the search.
   always_comb begin
      cand_pow = run_pow;
      cand_idx = run_idx;
      if ((Output_index == '0) || (Output_power > run_pow)) begin
         cand_pow = Output_power;
         cand_idx = Output_index;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         run_pow    <= '0;
         run_idx    <= '0;
         Peak_valid <= 1'b0;
         Peak_index <= '0;
         Peak_power <= '0;
      end else begin
         Peak_valid <= 1'b0;
         if (Output_valid) begin
            run_pow <= cand_pow;
            run_idx <= cand_idx;
            if (Output_last) begin
               Peak_valid <= 1'b1;
               Peak_index <= cand_idx;
               Peak_power <= cand_pow;
            end
         end
      end
   end
`else
   assign Peak_valid = 1'b0;
   assign Peak_index = '0;
   assign Peak_power = '0;
`endif
endmodule
